// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants
// Purpose: segment bit positions, hex-to-segment table (active-high) and the
//          blank pattern used by the scan driver and its decoder.
// Ports:   none (package)
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the active-high a..g pattern for nibble n (0..F).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to seven-segment decoder
// Purpose: maps a 4-bit nibble to active-high a..g; no dp, no polarity.
// Ports:   hex [3:0] in  - nibble to display
//          seg [6:0] out - bit0=a .. bit6=g, 1 = lit
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver
// Purpose: scans DIGITS hex nibbles onto one shared segment bus with one-hot
//          digit enables, frame-synchronous update, leading-zero blanking,
//          per-digit blink and dead time between slots.
// Ports:   clk              in  - system clock
//          rst_n            in  - synchronous active-low reset
//          load             in  - capture value/dots into pending register
//          value[4*DIGITS]  in  - nibble i drives digit i (digit 0 rightmost)
//          dots[DIGITS]     in  - decimal point per digit
//          blank_lz         in  - enable leading-zero blanking
//          blink_mask[DIGITS] in - digits that blink (sampled live)
//          segments[8]      out - bit0=a .. bit6=g, bit7=dp
//          digit_en[DIGITS] out - one-hot or all-off digit select
//          frame_done       out - one-cycle pulse after the scan wraps
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int DEAD           = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]       p;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic [4*DIGITS-1:0] pend_val, shad_val;
  logic [DIGITS-1:0]   pend_dots, shad_dots;

  logic                slot_end, wrap, in_dead, lz_blank, blink_off;
  logic [3:0]          nib;
  logic [6:0]          hex_seg;
  logic [7:0]          seg_hi;
  logic [DIGITS-1:0]   dig_hi;

  assign slot_end = (p == P_LAST);
  assign wrap     = slot_end && (idx == I_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p         <= '0;
      idx       <= '0;
      fcnt      <= '0;
      phase     <= 1'b0;
      pend_val  <= '0;
      pend_dots <= '0;
      shad_val  <= '0;
      shad_dots <= '0;
    end else begin
      p <= slot_end ? '0 : p + 1'b1;
      if (slot_end) begin
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        pend_val  <= value;
        pend_dots <= dots;
      end
      if (wrap) begin
        // A load coinciding with the wrap bypasses pending so it lands now.
        shad_val  <= load ? value : pend_val;
        shad_dots <= load ? dots  : pend_dots;
        if (fcnt == F_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (p < PW'(DEAD));
    end
  endgenerate

  assign nib = shad_val[{idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex (nib),
    .seg (hex_seg)
  );

  // Blank when this digit and every more-significant nibble are zero.
  always_comb begin
    lz_blank = blank_lz && (idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= idx) && (shad_val[4*i +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
  end

  assign blink_off = phase && blink_mask[idx];

  always_comb begin
    seg_hi = SEG_BLANK;
    dig_hi = '0;
    if (!in_dead) begin
      dig_hi = DIGITS'(1) << idx;
      if (!blink_off) begin
        seg_hi[6:0]    = lz_blank ? 7'h00 : hex_seg;
        seg_hi[SEG_DP] = shad_dots[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments   <= SEG_OFF;
      digit_en   <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_hi ^ SEG_OFF;
      digit_en   <= dig_hi ^ DIG_OFF;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int DEAD   = 2;
  localparam int BF     = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [7:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_fd  = -1;

  // Reference state: t = cycles since reset, plus pending/shadow contents.
  int          t;
  logic [15:0] pend_v, shad_v;
  logic [3:0]  pend_d, shad_d;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_en;
  logic        exp_fd;

  logic [6:0] hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS         (DIGITS),
    .DIV            (DIV),
    .DEAD           (DEAD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dots       (dots),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: predict the registered outputs from the pre-edge reference
  // state, advance the reference, then compare just after the edge.
  task automatic step();
    int         p, idx, wraps;
    bit         phase, lzb, blk;
    logic [3:0] nib;
    logic [7:0] seg_h;
    logic [3:0] en_h;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_seg = 8'hFF; exp_en = 4'hF; exp_fd = 1'b0;
      t = 0; pend_v = '0; shad_v = '0; pend_d = '0; shad_d = '0;
      last_fd = -1;
    end else begin
      p     = t % DIV;
      idx   = (t / DIV) % DIGITS;
      wraps = t / FRAME;
      phase = ((wraps / BF) % 2) == 1;
      exp_fd = (t % FRAME) == FRAME - 1;
      seg_h = 8'h00;
      en_h  = 4'h0;
      if (p >= DEAD) begin
        en_h  = 4'(1 << idx);
        lzb   = blank_lz && (idx != 0) && ((shad_v >> (4 * idx)) == 16'h0);
        blk   = phase && blink_mask[idx];
        nib   = 4'(shad_v >> (4 * idx));
        if (!blk) seg_h = {shad_d[idx], lzb ? 7'h00 : hex_ref[nib]};
      end
      exp_seg = ~seg_h;
      exp_en  = ~en_h;
      if (load) begin pend_v = value; pend_d = dots; end
      if (exp_fd) begin shad_v = pend_v; shad_d = pend_d; end
      t++;
    end
    #1;
    check("segments", {24'h0, segments}, {24'h0, exp_seg});
    check("digit_en", {28'h0, digit_en}, {28'h0, exp_en});
    check("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) check("fd_period", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dots = d;
    step();
    load = 1'b0;
  endtask

  // Advance until the reference state's position in the frame equals m.
  task automatic wait_pos(input int m);
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != m; k++) step();
  endtask

  // After reset release: digit 0 must be the first enabled, at cycle DEAD+1.
  task automatic check_first_enable(input string tag);
    int n = 0;
    while (n < 20 && digit_en === 4'hF) begin
      step();
      n++;
    end
    check({tag, "_first_en_cycle"}, n, DEAD + 1);
    check({tag, "_first_en_digit"}, {28'h0, digit_en}, 32'h0000_000E);
    check({tag, "_first_en_seg"}, {24'h0, segments}, 32'h0000_00C0);
  endtask

  initial begin
    int hold;
    rst_n = 1'b0; load = 1'b0; value = '0; dots = '0; blank_lz = 1'b0; blink_mask = '0;
    run(2);
    rst_n = 1'b1;
    check_first_enable("startup");

    // Basic hex pattern and frame period.
    pulse_load(16'h12AF, 4'h0);
    run(3 * FRAME);

    // Leading-zero blanking, including all-zero and dp on blanked digits.
    blank_lz = 1'b1;
    pulse_load(16'h0007, 4'b0100);
    run(2 * FRAME);
    pulse_load(16'h0000, 4'h0);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Mid-frame load at idx=1 must not tear the current frame.
    wait_pos(DIV + 3);
    pulse_load(16'h1111, 4'h0);
    run(2 * FRAME);

    // Load in the exact wrap cycle is committed at that wrap.
    wait_pos(FRAME - 1);
    pulse_load(16'h5A3C, 4'b1001);
    run(FRAME);

    // Blink on digit 2 across several blink periods.
    blink_mask = 4'b0100;
    run(8 * FRAME);
    blink_mask = 4'b0000;

    // Randomized traffic; loads sometimes held for several cycles.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        hold = $urandom_range(1, 4);
        load = 1'b1;
        for (int h = 0; h < hold; h++) begin
          for (int b = 0; b < 4; b++) value[4*b +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          dots = 4'($urandom);
          step();
        end
        load = 1'b0;
      end else begin
        if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
        if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
        value = 16'($urandom);
        step();
      end
    end
    blink_mask = 4'b0000;

    // Reset mid-frame at idx=2, p=5.
    pulse_load(16'hBEEF, 4'hF);
    run(FRAME);
    wait_pos(2 * DIV + 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_first_enable("midreset");
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
